// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: FSM state codes and the default operand width.
package div_unit_pkg;

    localparam int unsigned DivDataWidth = 32;

    typedef enum logic [1:0] {
        DivFree = 2'd0,
        DivOn   = 2'd1,
        DivDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on a {remainder, quotient} pair.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DivDataWidth
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] shifted;
    logic                ge;

    always_comb begin
        // One extra bit so the shifted partial remainder never overflows before the compare.
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        ge      = shifted >= {1'b0, divisor_i};
        rem_o   = ge ? DATA_WIDTH'(shifted - {1'b0, divisor_i}) : shifted[DATA_WIDTH-1:0];
        quo_o   = {quo_i[DATA_WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring DIV/DIVU unit for EX; result = {remainder, quotient}.
// Define DIV_ZERO_SHORTCUT_EN to finish a divide-by-zero in one cycle instead of DATA_WIDTH+1.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DivDataWidth
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    start,
    input  logic                    signed_div,
    input  logic [DATA_WIDTH-1:0]   opdata1,
    input  logic [DATA_WIDTH-1:0]   opdata2,
    input  logic                    ex_stall,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    ready,
    output logic                    stallreq
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    div_state_e              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    div_zero_q, div_zero_d;
    logic [2*DATA_WIDTH-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [DATA_WIDTH-1:0]   step_rem, step_quo;
    logic [DATA_WIDTH-1:0]   fix_rem, fix_quo;
    logic [DATA_WIDTH-1:0]   dvd_abs, dvs_abs;

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        dvd_abs = (signed_div && opdata1[DATA_WIDTH-1]) ? -opdata1 : opdata1;
        dvs_abs = (signed_div && opdata2[DATA_WIDTH-1]) ? -opdata2 : opdata2;
        // With a zero divisor the remainder accumulates |dividend|, so the usual remainder
        // fixup restores the original dividend; only the quotient fixup must be bypassed.
        fix_rem = neg_rem_q ? -step_rem : step_rem;
        fix_quo = div_zero_q ? {DATA_WIDTH{1'b1}} : (neg_quo_q ? -step_quo : step_quo);

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d = 1'b0;
                if (start && !flush) begin
                    rem_d      = '0;
                    quo_d      = dvd_abs;
                    dvs_d      = dvs_abs;
                    neg_quo_d  = signed_div & (opdata1[DATA_WIDTH-1] ^ opdata2[DATA_WIDTH-1]);
                    neg_rem_d  = signed_div & opdata1[DATA_WIDTH-1];
                    div_zero_d = (opdata2 == '0);
                    cnt_d      = '0;
                    state_d    = DivOn;
`ifdef DIV_ZERO_SHORTCUT_EN
                    if (opdata2 == '0) begin
                        result_d = {opdata1, {DATA_WIDTH{1'b1}}};
                        ready_d  = 1'b1;
                        state_d  = DivDone;
                    end
`endif
                end
            end
            DivOn: begin
                if (flush || !start) begin
                    state_d = DivFree;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                        state_d  = DivDone;
                    end
                end
            end
            DivDone: begin
                if (flush || !ex_stall) begin
                    ready_d = 1'b0;
                    state_d = DivFree;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result   = result_q;
    assign ready    = ready_q;
    // Purely from state and start, never from ex_stall, so no loop through the stall controller.
    assign stallreq = start & (state_q != DivDone) & resetn;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; honours DIV_ZERO_SHORTCUT_EN for zero-divisor latency.
module tb_div_unit;

    localparam int unsigned W = 32;
`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 33;
`endif

    logic           clk;
    logic           resetn;
    logic           flush;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           ex_stall;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stallreq;

    int errors = 0;
    int checks = 0;

    div_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .ex_stall   (ex_stall),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one divide with start held; cycle 0 is the FREE cycle where start is first seen.
    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2*W-1:0] res, output int stall_gaps);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        ex_stall   = 1'b0;
        lat        = 0;
        stall_gaps = 0;
        #1;
        if (stallreq !== 1'b1) stall_gaps++;
        while (ready !== 1'b1 && lat < 60) begin
            tick();
            lat++;
            if (lat == 1) begin
                opdata1 = ~a;
                opdata2 = ~b;
            end
            if (ready !== 1'b1 && stallreq !== 1'b1) stall_gaps++;
        end
        res = result;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; start = 1'b1; signed_div = 1'b0;
        opdata1 = 32'd100; opdata2 = 32'd7; ex_stall = 1'b0;
        tick(); tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b result=%h, want 0 and 0", ready, result);
        end
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_stallreq: got %b want 0", stallreq);
        end
        start = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic finish_div(input string name);
        start = 1'b0;
        ex_stall = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: ready=%b want 0", name, ready);
        end
    endtask

    task automatic test_divide(input string name, input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int exp_lat,
                               input logic [2*W-1:0] exp_res);
        int lat, gaps;
        logic [2*W-1:0] res;
        do_div(sgn, a, b, lat, res, gaps);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s_result: got %h want %h", name, res, exp_res);
        end
        checks++;
        if (gaps != 0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL %s_stallreq: gaps=%0d done_stallreq=%b want 0 and 0",
                     name, gaps, stallreq);
        end
        finish_div(name);
    endtask

    task automatic test_flush_on();
        int seen;
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL flush_on_stallreq: got %b want 0", stallreq);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_on_ready: ready high %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_flush_beats_start();
        int lat, gaps;
        logic [2*W-1:0] res;
        signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        do_div(1'b0, 32'd9, 32'd3, lat, res, gaps);
        checks++;
        if (lat != 33 || res !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL flush_beats_start: lat=%0d res=%h want 33 and %h",
                     lat, res, {32'd0, 32'd3});
        end
        finish_div("flush_beats_start");
    endtask

    task automatic test_flush_done();
        int lat, gaps;
        logic [2*W-1:0] res;
        do_div(1'b0, 32'd3, 32'd10, lat, res, gaps);
        ex_stall = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ready !== 1'b0 || result !== {32'd3, 32'd0}) begin
            errors++;
            $display("FAIL flush_done: ready=%b result=%h want 0 and %h",
                     ready, result, {32'd3, 32'd0});
        end
        finish_div("flush_done");
    endtask

    task automatic test_back_to_back();
        int lat, gaps, held;
        logic [2*W-1:0] res;
        do_div(1'b0, 32'd100, 32'd7, lat, res, gaps);
        ex_stall = 1'b1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready === 1'b1 && result === {32'd2, 32'd14}) held++;
        end
        checks++;
        if (lat != 33 || held != 3) begin
            errors++;
            $display("FAIL stall_hold: lat=%0d held=%0d want 33 and 3", lat, held);
        end
        ex_stall = 1'b0;
        opdata1 = 32'd9;
        opdata2 = 32'd3;
        tick();
        checks++;
        if (ready !== 1'b0 || stallreq !== 1'b1 || result !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b stallreq=%b result=%h want 0 1 %h",
                     ready, stallreq, result, {32'd2, 32'd14});
        end
        do_div(1'b0, 32'd9, 32'd3, lat, res, gaps);
        checks++;
        if (lat != 33 || res !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d res=%h want 33 and %h",
                     lat, res, {32'd0, 32'd3});
        end
        finish_div("b2b");
    endtask

    task automatic test_reset_mid_on();
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_on: ready=%b result=%h stallreq=%b want all 0",
                     ready, result, stallreq);
        end
        start = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_divide("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        test_divide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        test_divide("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
        test_divide("divu_5_0", 1'b0, 32'd5, 32'd0, ZeroLat, {32'd5, 32'hFFFF_FFFF});
        test_divide("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, ZeroLat,
                    {32'hFFFF_FFF8, 32'hFFFF_FFFF});
        test_divide("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
                    {32'd0, 32'h8000_0000});
        test_divide("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF});
        test_divide("divu_big_signed_ops", 1'b0, 32'hFFFF_FFF9, 32'd2, 33,
                    {32'd1, 32'h7FFF_FFFC});
        test_flush_on();
        test_flush_beats_start();
        test_flush_done();
        test_back_to_back();
        test_reset_mid_on();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
